// File: rtl/game_timer.sv
// game_timer: countdown timer that drives time_remain for the game state machine.
// The system clock is divided down to a 1-second tick. The timer counts down only
// while cnt_enable is high, and it holds at zero once the time has expired.
// Optional bonus-time input: define GAME_TIMER_BONUS_EN to add the bonus port.
module game_timer #(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned START_SEC = 10,
  parameter int unsigned LOW_SEC   = 3,
  parameter int unsigned BONUS_SEC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       cnt_enable,
`ifdef GAME_TIMER_BONUS_EN
  input  logic       bonus,
`endif
  output logic [3:0] time_remain,
  output logic       tick_1s,
  output logic       time_up,
  output logic       low_time
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [26:0] TICK_MAX  = 27'(TICK_DIV - 1);
  localparam logic [3:0]  START_VAL = 4'(START_SEC);
  localparam logic [3:0]  LOW_VAL   = 4'(LOW_SEC);
  localparam logic [5:0]  BONUS_VAL = 6'(BONUS_SEC);

  state_t      state, state_n;
  logic [26:0] prescaler, prescaler_n;
  logic [3:0]  time_n;
  logic        tick_n;
  logic        time_up_n;
  logic        low_time_n;
  logic        counting;
  logic        bonus_hit;
  logic [5:0]  sum;

  // Bonus time is accepted only while a round is in progress (RUN or HOLD).
`ifdef GAME_TIMER_BONUS_EN
  assign bonus_hit = bonus && ((state == RUN) || (state == HOLD));
`else
  assign bonus_hit = 1'b0;
`endif

  // The prescaler advances in RUN, and also on the first enabled cycle out of HOLD,
  // so that counting resumes immediately from the frozen value.
  assign counting = ((state == RUN) || (state == HOLD)) && cnt_enable;

  // Next-state logic. The time arithmetic uses 6 bits so that bonus plus tick can
  // saturate at 15 and can never underflow. game_start overrides everything else.
  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    time_n      = time_remain;
    tick_n      = 1'b0;
    sum         = {2'b00, time_remain} + (bonus_hit ? BONUS_VAL : 6'd0);

    case (state)
      IDLE: begin
        time_n      = START_VAL;
        prescaler_n = '0;
      end
      RUN, HOLD: begin
        if (counting) begin
          state_n = RUN;
          if (prescaler == TICK_MAX) begin
            prescaler_n = '0;
            tick_n      = 1'b1;
            if (sum != 6'd0) begin
              sum = sum - 6'd1;
            end
          end else begin
            prescaler_n = prescaler + 27'd1;
          end
        end else begin
          state_n = HOLD;
        end
        time_n = (sum > 6'd15) ? 4'd15 : sum[3:0];
        if (tick_n && (time_n == 4'd0)) begin
          state_n = EXPIRED;
        end
      end
      EXPIRED: begin
        time_n = 4'd0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (game_start) begin
      state_n     = RUN;
      prescaler_n = '0;
      time_n      = START_VAL;
      tick_n      = 1'b0;
    end

    time_up_n  = tick_n && (time_n == 4'd0);
    low_time_n = (time_n != 4'd0) && (time_n <= LOW_VAL);
  end

  // State and outputs are registered together. Because of this, time_up and
  // low_time line up with the time_remain value they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      prescaler   <= '0;
      time_remain <= START_VAL;
      tick_1s     <= 1'b0;
      time_up     <= 1'b0;
      low_time    <= 1'b0;
    end else begin
      state       <= state_n;
      prescaler   <= prescaler_n;
      time_remain <= time_n;
      tick_1s     <= tick_n;
      time_up     <= time_up_n;
      low_time    <= low_time_n;
    end
  end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Countdown timer that produces the `time_remain` value consumed by the game state machine.
- Divides the system clock down to a 1-second tick.
- Loads the round duration on `game_start` and counts down only while `cnt_enable` is high.
- Holds at zero when expired; flags low-time for the display and a one-cycle time-up pulse.

Parameters:
- TICK_DIV, 100000000, clk cycles per 1-second tick (>=2); prescaler width is 27 bits.
- START_SEC, 10, seconds loaded at round start (1..15).
- LOW_SEC, 3, `low_time` asserts when 0 < time_remain <= LOW_SEC.
- BONUS_SEC, 2, seconds added per bonus (optional feature only).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- game_start, input, 1, one-cycle pulse that starts a round.
- cnt_enable, input, 1, level; countdown runs only while high.
- bonus, input, 1, one-cycle pulse that adds time; present only when GAME_TIMER_BONUS_EN is defined.
- time_remain, output, 4, seconds left (registered).
- tick_1s, output, 1, one-cycle pulse on each second boundary while running.
- time_up, output, 1, one-cycle pulse in the cycle time_remain becomes 0.
- low_time, output, 1, level; registered low-time warning.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE, prescaler = 0.
  - time_remain = START_SEC; tick_1s = 0, time_up = 0, low_time = 0.
- States: IDLE, RUN, HOLD, EXPIRED (2-bit encoding).
- IDLE:
  - time_remain is held at START_SEC; prescaler held at 0.
  - On game_start: go to RUN, time_remain = START_SEC, prescaler = 0.
- RUN:
  - If cnt_enable = 1, the prescaler increments each cycle.
  - When prescaler = TICK_DIV-1: prescaler wraps to 0, tick_1s pulses for 1 cycle, and time_remain decrements in that same edge.
  - If cnt_enable = 0: go to HOLD; prescaler is frozen, not cleared.
- HOLD:
  - Everything is frozen.
  - cnt_enable = 1 returns to RUN; counting resumes from the frozen prescaler value.
- Reaching zero:
  - A decrement taking time_remain from 1 to 0 moves the block to EXPIRED.
  - time_up pulses high in the cycle after that edge, coincident with time_remain = 0.
- EXPIRED:
  - time_remain holds 0; no ticks, no further time_up.
  - Exit only via game_start or reset.
- game_start from any state:
  - Highest priority: reloads START_SEC, clears the prescaler, goes to RUN.
  - Overrides a same-cycle tick or bonus.
- Latency:
  - time_remain updates on the same clock edge as the tick.
  - low_time and time_up are registered off the next-state value, so they align with the new time_remain.
- Arithmetic:
  - time_remain never underflows; decrement is only allowed when the value is > 0.
  - The prescaler compare uses the full 27-bit width.
- Reset mid-round: immediate return to reset values; no time_up pulse is generated.

Optional Feature:
- Macro: GAME_TIMER_BONUS_EN.
- When defined:
  - The bonus port exists.
  - In RUN or HOLD, a bonus pulse adds BONUS_SEC to time_remain, saturating at 15.
- Same-cycle bonus and tick:
  - Net result is time_remain + BONUS_SEC - 1, saturating at 15.
  - tick_1s still pulses.
  - If the net result is > 0, EXPIRED is not entered.
- bonus is ignored in IDLE and EXPIRED.
- When the macro is undefined:
  - No bonus port.
  - time_remain only decreases or reloads.

Test Plan:
- Reset check (TICK_DIV=4, START_SEC=10): assert rst mid-count -> time_remain=10, tick_1s=0, time_up=0, low_time=0 within the same cycle (asynchronous).
- Basic countdown: game_start, then cnt_enable held high ->
  - tick_1s every 4 cycles; time_remain 10,9,...,1,0.
  - low_time high at 3,2,1 and low at 0.
  - time_up high for exactly 1 cycle, coincident with time_remain=0; no further ticks afterwards.
- Pause: drop cnt_enable after 2 cycles into a second for 20 cycles, then raise it -> time_remain unchanged during the pause; next tick arrives 2 cycles after resume.
- Restart: game_start while in EXPIRED, and again at time_remain=5 coincident with a tick -> time_remain=10, prescaler restarts, no decrement that cycle.
- Bonus (with GAME_TIMER_BONUS_EN, BONUS_SEC=2):
  - bonus at time_remain=14 -> 15 (saturated).
  - bonus coincident with a tick at time_remain=1 -> 2, with no time_up.
  - bonus in EXPIRED -> remains 0.
- Macro off: identical run to the basic countdown produces an identical trace; bench confirms the bonus port is absent.
